// File: rtl/hybrid_adder_pipe.sv
// Pipelined ripple-carry adder with a runtime-selectable approximate LSB region and valid/ready flow.
// Optional error statistics (exact-sum comparison and saturating counter) under HYBRID_ADDER_ERR_STATS_EN.
module hybrid_adder_pipe #(
  parameter int WIDTH      = 18,
  parameter int STAGES     = 2,
  parameter int APPROX_MAX = 9,
  parameter int AW         = (APPROX_MAX > 0) ? $clog2(APPROX_MAX + 1) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic [AW-1:0]    i_approx_bits,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_err,
  output logic [15:0]      o_err_cnt
);

  localparam int SEG = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_cfg
    $error("hybrid_adder_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  function automatic int clamp_approx(input logic [AW-1:0] n);
    if (int'(n) > APPROX_MAX) return APPROX_MAX;
    return int'(n);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [WIDTH-1:0] mask_in;

  always_comb begin
    int n_eff;
    n_eff   = clamp_approx(i_approx_bits);
    mask_in = '0;
    for (int j = 0; j < WIDTH; j++) mask_in[j] = (j < n_eff);
  end

`ifdef HYBRID_ADDER_ERR_STATS_EN
  logic [WIDTH:0] ex_in0;
  assign ex_in0 = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_c};
`endif

  // Each rank resolves one SEG-bit slice; only the still-unresolved operand bits travel upward.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int  IW   = WIDTH - k * SEG;
    localparam int  LW   = k * SEG;
    localparam bit  LAST = (k == STAGES - 1);

    logic [IW-1:0]     a_in, b_in, m_in;
    logic              cy_in, vld_in, adv;
    logic [SEG-1:0]    seg_s;
    logic              seg_c;
    logic [LW+SEG-1:0] s_d;
    logic [LW+SEG-1:0] s_q;
    logic              cy_q, vld_q;
`ifdef HYBRID_ADDER_ERR_STATS_EN
    logic [WIDTH:0]    ex_in;
`endif

    if (k == 0) begin : g_in
      assign a_in   = i_a;
      assign b_in   = i_b;
      assign m_in   = mask_in;
      assign cy_in  = i_c;
      assign vld_in = i_valid;
      assign s_d    = seg_s;
`ifdef HYBRID_ADDER_ERR_STATS_EN
      assign ex_in  = ex_in0;
`endif
    end else begin : g_in
      assign a_in   = g_st[k-1].g_ops.a_q;
      assign b_in   = g_st[k-1].g_ops.b_q;
      assign m_in   = g_st[k-1].g_ops.m_q;
      assign cy_in  = g_st[k-1].cy_q;
      assign vld_in = g_st[k-1].vld_q;
      assign s_d    = {seg_s, g_st[k-1].s_q};
`ifdef HYBRID_ADDER_ERR_STATS_EN
      assign ex_in  = g_st[k-1].g_ops.ex_q;
`endif
    end

    if (LAST) begin : g_adv
      assign adv = ~vld_q | i_ready;
    end else begin : g_adv
      assign adv = ~vld_q | g_st[k+1].adv;
    end

    always_comb begin
      logic c;
      logic mj;
      c     = cy_in;
      mj    = 1'b0;
      seg_s = '0;
      for (int i = 0; i < SEG; i++) begin
        mj       = maj3(a_in[i], b_in[i], c);
        seg_s[i] = m_in[i] ? ~mj : (a_in[i] ^ b_in[i] ^ c);
        c        = mj;
      end
      seg_c = c;
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) vld_q <= 1'b0;
      else if (adv) vld_q <= vld_in;
    end

    // Output rank clears its data on reset so the ports read zero; inner ranks carry data only.
    always_ff @(posedge i_clk) begin
      if (LAST && !i_rst_n) begin
        s_q  <= '0;
        cy_q <= 1'b0;
      end else if (adv && vld_in) begin
        s_q  <= s_d;
        cy_q <= seg_c;
      end
    end

    if (!LAST) begin : g_ops
      localparam int UW = IW - SEG;
      logic [UW-1:0] a_q, b_q, m_q;
`ifdef HYBRID_ADDER_ERR_STATS_EN
      logic [WIDTH:0] ex_q;
      always_ff @(posedge i_clk) begin
        if (adv && vld_in) ex_q <= ex_in;
      end
`endif
      always_ff @(posedge i_clk) begin
        if (adv && vld_in) begin
          a_q <= a_in[IW-1:SEG];
          b_q <= b_in[IW-1:SEG];
          m_q <= m_in[IW-1:SEG];
        end
      end
    end
  end

  assign o_valid = g_st[STAGES-1].vld_q;
  assign o_s     = g_st[STAGES-1].s_q;
  assign o_c     = g_st[STAGES-1].cy_q;
  assign o_ready = g_st[0].adv & i_rst_n;

`ifdef HYBRID_ADDER_ERR_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        err_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (g_st[STAGES-1].adv && g_st[STAGES-1].vld_in)
        err_q <= ({g_st[STAGES-1].seg_c, g_st[STAGES-1].s_d} != g_st[STAGES-1].ex_in);
      if (o_valid && i_ready && err_q)
        err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_err     = 1'b0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_hybrid_adder_pipe.sv
// Randomized and directed bench for hybrid_adder_pipe against an arithmetic reference model.
// Error-statistics checks follow HYBRID_ADDER_ERR_STATS_EN, same as the design.
module tb_hybrid_adder_pipe;
  localparam int WIDTH      = 18;
  localparam int STAGES     = 2;
  localparam int APPROX_MAX = 9;
  localparam int AW         = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0, i_ready = 1'b1, i_c = 1'b0;
  logic [WIDTH-1:0] i_a = '0, i_b = '0;
  logic [AW-1:0]    i_approx_bits = '0;
  logic             o_ready, o_valid, o_c, o_err;
  logic [WIDTH-1:0] o_s;
  logic [15:0]      o_err_cnt;

  hybrid_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .APPROX_MAX(APPROX_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_approx_bits(i_approx_bits),
    .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_c(o_c),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WIDTH:0] sum; logic err; int t_in; } txn_t;
  txn_t q[$];

  int          checks = 0, errors = 0, cyc = 0, got_lat = -1, out_cnt = 0;
  logic [15:0] model_cnt = '0;
  logic [WIDTH:0] last_out = '0;
  logic        last_err = 1'b0, last_in_fire = 1'b0;
  logic [WIDTH-1:0] samp_s = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Approximate bit j outputs the inverse of the true carry out of the low j+1 bits.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic c, input int n);
    logic [63:0] ex, low, m;
    logic [WIDTH:0] r;
    int eff;
    eff = (n > APPROX_MAX) ? APPROX_MAX : n;
    ex  = 64'(a) + 64'(b) + 64'(c);
    r   = ex[WIDTH:0];
    for (int j = 0; j < eff; j++) begin
      m    = (64'd1 << (j + 1)) - 64'd1;
      low  = (64'(a) & m) + (64'(b) & m) + 64'(c);
      r[j] = ~low[j+1];
    end
    return r;
  endfunction

  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input logic [AW-1:0] n, input logic rdy);
    txn_t e;
    logic out_fire, in_fire;
    logic [WIDTH:0] ex;
    @(negedge clk);
    i_valid = v; i_a = a; i_b = b; i_c = c; i_approx_bits = n; i_ready = rdy;
    #1;
    samp_s = o_s;
    chk("ready", {31'd0, o_ready}, {31'd0, (q.size() < STAGES) | rdy});
    if (q.size() == 0) chk("idle_valid", {31'd0, o_valid}, 32'd0);
`ifdef HYBRID_ADDER_ERR_STATS_EN
    chk("err_cnt", {16'd0, o_err_cnt}, {16'd0, model_cnt});
`else
    chk("err_cnt_off", {16'd0, o_err_cnt}, 32'd0);
`endif
    out_fire = o_valid & rdy;
    in_fire  = v & o_ready;
    if (out_fire) begin
      out_cnt++;
      last_out = {o_c, o_s};
      last_err = o_err;
      if (q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        got_lat = cyc - e.t_in;
        chk("sum", {13'd0, o_c, o_s}, {13'd0, e.sum});
`ifdef HYBRID_ADDER_ERR_STATS_EN
        chk("err", {31'd0, o_err}, {31'd0, e.err});
        if (e.err && model_cnt != 16'hFFFF) model_cnt++;
`else
        chk("err_off", {31'd0, o_err}, 32'd0);
`endif
      end
    end
    if (in_fire) begin
      e.sum  = ref_sum(a, b, c, int'(n));
      ex     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      e.err  = (e.sum != ex);
      e.t_in = cyc;
      q.push_back(e);
    end
    last_in_fire = in_fire;
    cyc++;
  endtask

  task automatic drain(input int maxc);
    for (int k = 0; k < maxc && q.size() > 0; k++) drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("drain_empty", q.size(), 32'd0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_s", {14'd0, o_s}, 32'd0);
    chk("rst_c", {31'd0, o_c}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_cnt", {16'd0, o_err_cnt}, 32'd0);
    chk("rst_ready2", {31'd0, o_ready}, 32'd0);
    q.delete();
    model_cnt = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] ta [4];
    logic [WIDTH-1:0] held;
    int idx, base_out;
    repeat (2) @(negedge clk);
    do_reset();

    // Exact wrap with latency
    drive_cycle(1'b1, 18'h3FFFF, 18'h00001, 1'b0, 4'd0, 1'b1);
    drain(8);
    chk("t1_sum", {13'd0, last_out}, 32'h40000);
    chk("t1_lat", got_lat, STAGES);

    // Approximate LSBs, then clamped selector
    drive_cycle(1'b1, '0, '0, 1'b0, 4'd9, 1'b1);
    drain(8);
    chk("t2_sum", {13'd0, last_out}, 32'h001FF);
`ifdef HYBRID_ADDER_ERR_STATS_EN
    chk("t2_err", {31'd0, last_err}, 32'd1);
`endif
    drive_cycle(1'b1, '0, '0, 1'b0, 4'd15, 1'b1);
    drain(8);
    chk("t2_clamp", {13'd0, last_out}, 32'h001FF);

    drive_cycle(1'b1, 18'h001FF, 18'h00001, 1'b0, 4'd9, 1'b1);
    drain(8);
    chk("t3_sum", {13'd0, last_out}, 32'h00200);
    chk("t3_err", {31'd0, last_err}, 32'd0);

    // Back-pressure: 3 stalled cycles starting at the first o_valid
    ta[0] = 18'h00011; ta[1] = 18'h00222; ta[2] = 18'h03333; ta[3] = 18'h24444;
    idx = 0; held = '0; base_out = out_cnt;
    for (int k = 0; k < 30 && idx < 4; k++) begin
      drive_cycle(1'b1, ta[idx], 18'h10101, idx[0], 4'(idx * 3), !(k >= 2 && k <= 4));
      if (k == 2) held = samp_s;
      if (k == 3 || k == 4) begin
        chk("t4_hold", {14'd0, samp_s}, {14'd0, held});
        chk("t4_full_ready", {31'd0, o_ready}, 32'd0);
      end
      if (last_in_fire) idx++;
    end
    chk("t4_accepted", idx, 4);
    drain(12);
    chk("t4_delivered", out_cnt - base_out, 4);

    // Reset with two transactions in flight
    drive_cycle(1'b1, 18'h12345, 18'h00777, 1'b1, 4'd2, 1'b1);
    drive_cycle(1'b1, 18'h2AAAA, 18'h15555, 1'b0, 4'd5, 1'b1);
    do_reset();
    drive_cycle(1'b1, 18'd5, 18'd7, 1'b0, 4'd0, 1'b1);
    drain(8);
    chk("t5_sum", {13'd0, last_out}, 32'd12);

`ifdef HYBRID_ADDER_ERR_STATS_EN
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, '0, '0, 1'b0, 4'd9, 1'b1);
    drain(8);
    chk("t6_cnt3", {16'd0, o_err_cnt}, 32'd3);
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFF;
    #1 release dut.err_cnt_q;
    model_cnt = 16'hFFFF;
    drive_cycle(1'b1, '0, '0, 1'b0, 4'd9, 1'b1);
    drain(8);
    chk("t6_sat", {16'd0, o_err_cnt}, 32'h0000FFFF);
`endif

    // Randomized traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      drive_cycle(($urandom_range(0, 9) < 7), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom), AW'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
